paddle_move_ctrl: RTL



---
 rtl/bb_pkg.sv | 12 +
 rtl/paddle_move_ctrl_rate_tick.sv | 19 +
 rtl/paddle_move_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bb_pkg.sv
// bb_pkg: shared play-state encodings, move codes, motion FSM states and direction decode.
package bb_pkg;
   localparam logic [2:0] ST_PLAY0 = 3'b001;
   localparam logic [2:0] ST_PLAY1 = 3'b010;
   localparam logic [7:0] MOVE_RIGHT = 8'h00;
   localparam logic [7:0] MOVE_LEFT = 8'h01;
   localparam logic [7:0] MOVE_NONE = 8'hFF;
   typedef enum logic [1:0] {IDLE, SLOW, FAST} move_state_t;
   function automatic logic [7:0] dir_code(input logic left, input logic right);
      return (left && !right) ? MOVE_LEFT : (right && !left) ? MOVE_RIGHT : MOVE_NONE;
   endfunction
endpackage

// File: rtl/paddle_move_ctrl_rate_tick.sv
// rate_tick: loadable down-counter that stops at zero and flags it.
module rate_tick #(
   parameter int W = 20
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);
   logic [W-1:0] count;
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) count <= '0;
      else if (load) count <= load_val;
      else if (dec && count != '0) count <= count - 1'b1;
   end
   assign zero = (count == '0);
endmodule

// File: rtl/paddle_move_ctrl.sv
// paddle_move_ctrl: arbitrated, auto-repeating (slow then fast) paddle step strobes.
// Optional computer player source enabled by defining PADDLE_AUTOPLAY_EN.
module paddle_move_ctrl import bb_pkg::*; #(
   parameter int SLOW_DIV    = 833333,
   parameter int FAST_DIV    = 416666,
   parameter int DIV_W       = 20,
   parameter int ACCEL_STEPS = 8,
   parameter int PADDLE_LEN  = 32
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [2:0] state,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       kb_left,
   input  logic       kb_right,
   output logic       move_en,
   output logic [7:0] move_code,
   output logic [2:0] grant,
   output logic       fast
`ifdef PADDLE_AUTOPLAY_EN
   ,
   input  logic       auto_mode,
   input  logic [7:0] ball_x,
   input  logic [7:0] paddle_x
`endif
);
   localparam logic [DIV_W-1:0] SLOW_LD = DIV_W'(SLOW_DIV - 1);
   localparam logic [DIV_W-1:0] FAST_LD = DIV_W'(FAST_DIV - 1);
   localparam logic [4:0] ACCEL = 5'(ACCEL_STEPS);

   if (FAST_DIV < 2 || FAST_DIV > SLOW_DIV || ACCEL_STEPS < 1 || ACCEL_STEPS > 15 ||
       PADDLE_LEN < 2 || PADDLE_LEN > 255 || SLOW_DIV - 1 >= 2 ** DIV_W) begin : g_bad_params
      $error("paddle_move_ctrl: illegal parameter set");
   end

   move_state_t fsm, fsm_nx;
   logic [2:0] grant_nx;
   logic [7:0] code_nx, d0, d1, d2, own;
   logic [4:0] steps, steps_nx;
   logic [DIV_W-1:0] load_val;
   logic en_nx, play, load, zero, go_fast;

   assign play = (state == ST_PLAY0) || (state == ST_PLAY1);
   assign d0 = dir_code(btn_left, btn_right);
   assign d1 = dir_code(kb_left, kb_right);
`ifdef PADDLE_AUTOPLAY_EN
   logic [8:0] centre;
   assign centre = {1'b0, paddle_x} + 9'(PADDLE_LEN / 2);
   // auto only speaks when both humans are silent
   assign d2 = (!auto_mode || d0 != MOVE_NONE || d1 != MOVE_NONE) ? MOVE_NONE :
               ({1'b0, ball_x} + 9'd4 < centre) ? MOVE_LEFT :
               ({1'b0, ball_x} > centre + 9'd4) ? MOVE_RIGHT : MOVE_NONE;
`else
   assign d2 = MOVE_NONE;
`endif
   assign own = grant[0] ? d0 : grant[1] ? d1 : grant[2] ? d2 : MOVE_NONE;
   assign go_fast = (fsm == SLOW) && !grant[2] && (steps == ACCEL);

   always_comb begin
      fsm_nx = fsm;
      grant_nx = grant;
      code_nx = move_code;
      en_nx = 1'b0;
      steps_nx = steps;
      load = 1'b0;
      load_val = SLOW_LD;
      if (fsm == IDLE) begin
         if (play && (d0 != MOVE_NONE || d1 != MOVE_NONE || d2 != MOVE_NONE)) begin
            fsm_nx = SLOW;
            grant_nx = (d0 != MOVE_NONE) ? 3'b001 : (d1 != MOVE_NONE) ? 3'b010 : 3'b100;
            code_nx = (d0 != MOVE_NONE) ? d0 : (d1 != MOVE_NONE) ? d1 : d2;
            en_nx = 1'b1;
            steps_nx = 5'd1;
            load = 1'b1;
         end
      end else if (!play || own == MOVE_NONE) begin
         fsm_nx = IDLE;
         grant_nx = 3'b000;
         code_nx = MOVE_NONE;
         steps_nx = 5'd0;
      end else if (own != move_code && !move_en) begin
         // reversal restarts the press; deferred one cycle if a pulse is already out
         fsm_nx = SLOW;
         code_nx = own;
         en_nx = 1'b1;
         steps_nx = 5'd1;
         load = 1'b1;
      end else if (zero) begin
         fsm_nx = go_fast ? FAST : fsm;
         en_nx = 1'b1;
         steps_nx = (fsm == SLOW && !grant[2]) ? steps + 5'd1 : steps;
         load = 1'b1;
         load_val = (go_fast || fsm == FAST) ? FAST_LD : SLOW_LD;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         fsm <= IDLE;
         grant <= 3'b000;
         move_code <= MOVE_NONE;
         move_en <= 1'b0;
         steps <= 5'd0;
      end else begin
         fsm <= fsm_nx;
         grant <= grant_nx;
         move_code <= code_nx;
         move_en <= en_nx;
         steps <= steps_nx;
      end
   end

   assign fast = (fsm == FAST);

   rate_tick #(.W(DIV_W)) u_rate (
      .clock    (clock),
      .resetn   (resetn),
      .load     (load),
      .load_val (load_val),
      .dec      (fsm != IDLE),
      .zero     (zero)
   );
endmodule
